// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the multi-port integer register file.
// Optional build macro used by this slice: REGFILE_SYNC_READ_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Architectural x0: reads as zero, writes are dropped.
    localparam int ZERO_REG = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-side bus of the register file; the pipeline is master, regfile_mp is slave.
interface regfile_if #(
    parameter  int XLEN  = regfile_pkg::XLEN_DEF,
    parameter  int NREGS = regfile_pkg::NREGS_DEF,
    parameter  int NRD   = regfile_pkg::NRD_DEF,
    localparam int AW    = $clog2(NREGS)
);

    logic                  init_done;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [NRD-1:0]        rd_en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  alloc_en;
    logic [AW-1:0]         alloc_addr;
    logic                  flush;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, alloc_en, alloc_addr, flush,
        input  init_done, rd_data, rd_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, alloc_en, alloc_addr, flush,
        output init_done, rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_rdport.sv
// One read port: x0/enable masking, write bypass and hazard flag.
// With REGFILE_SYNC_READ_EN defined the outputs are registered (1-cycle latency).
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 5
) (
`ifdef REGFILE_SYNC_READ_EN
    input  logic            clk,
    input  logic            rst,
`endif
    input  logic            ready,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] reg_data,
    input  logic            pend,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic            live;
    logic            hit;
    logic [XLEN-1:0] data_c;
    logic            busy_c;

    // A same-cycle writeback both supplies the data and resolves the hazard.
    always_comb begin
        live   = ready && rd_en && (rd_addr != AW'(ZERO_REG));
        hit    = wr_en && (wr_addr == rd_addr);
        data_c = '0;
        busy_c = 1'b0;
        if (live) begin
            data_c = hit ? wr_data : reg_data;
            busy_c = pend && !hit;
        end
    end

`ifdef REGFILE_SYNC_READ_EN
    logic [XLEN-1:0] data_q;
    logic            busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_c;
            busy_q <= busy_c;
        end
    end

    assign rd_data = data_q;
    assign rd_busy = busy_q;
`else
    assign rd_data = data_c;
    assign rd_busy = busy_c;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with post-reset zero sweep and pending scoreboard.
// Build macro REGFILE_SYNC_READ_EN selects registered read ports (default: combinational).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = NRD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    state_e            state_q;
    state_e            state_d;
    logic [AW-1:0]     sweep_idx_q;
    logic              sweep_we;
    logic              ready;
    logic              wr_fire;
    logic [XLEN-1:0]   mem [NREGS];
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  pending_d;

    logic [AW-1:0]     port_addr [NRD];
    logic [XLEN-1:0]   port_data [NRD];
    logic              port_busy [NRD];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_CLEAR;
        else      state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (sweep_idx_q == AW'(NREGS - 1)) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        sweep_we = 1'b0;
        ready    = 1'b0;
        case (state_q)
            ST_CLEAR: sweep_we = 1'b1;
            ST_READY: ready    = 1'b1;
            default:  ;
        endcase
    end

    assign bus.init_done = ready;

    // Index stops at NREGS-1 so it never wraps; the FSM leaves CLEAR on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sweep_idx_q <= AW'(1);
        else if (sweep_we && (sweep_idx_q != AW'(NREGS - 1)))
            sweep_idx_q <= sweep_idx_q + AW'(1);
    end

    assign wr_fire = ready && bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));

    // NOTE: the array has no reset so it can map onto RAM; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (sweep_we)
            mem[sweep_idx_q] <= '0;
        else if (wr_fire)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    // Flush beats alloc, alloc beats a same-address writeback.
    always_comb begin
        pending_d = pending_q;
        if (ready) begin
            if (bus.flush) begin
                pending_d = '0;
            end else begin
                if (bus.wr_en)    pending_d[bus.wr_addr]    = 1'b0;
                if (bus.alloc_en) pending_d[bus.alloc_addr] = 1'b1;
            end
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign port_addr[i] = bus.rd_addr[i*AW +: AW];

        regfile_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_port (
`ifdef REGFILE_SYNC_READ_EN
            .clk      (clk),
            .rst      (rst),
`endif
            .ready    (ready),
            .rd_en    (bus.rd_en[i]),
            .rd_addr  (port_addr[i]),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .reg_data (mem[port_addr[i]]),
            .pend     (pending_q[port_addr[i]]),
            .rd_data  (port_data[i]),
            .rd_busy  (port_busy[i])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd_data[i*XLEN +: XLEN] = port_data[i];
            bus.rd_busy[i]              = port_busy[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=4) against an array-based reference model.
// Honours REGFILE_SYNC_READ_EN to move the read-port check after the clock edge.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = $clog2(NREGS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_pend [NREGS];
    bit              m_ready;
    int              m_sweep;

    logic [XLEN-1:0] e_data [NRD];
    bit              e_busy [NRD];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
        bus.flush      = 1'b0;
        bus.rd_en      = '0;
        bus.rd_addr    = '0;
    endtask

    task automatic set_rd(input int p, input bit en, input int a);
        bus.rd_en[p]            = en;
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input bit en, input int a, input logic [XLEN-1:0] d);
        bus.wr_en   = en;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
    endtask

    task automatic set_alloc(input bit en, input int a);
        bus.alloc_en   = en;
        bus.alloc_addr = AW'(a);
    endtask

    task automatic rand_stim(input int hi);
        bus.wr_en      = ($urandom_range(99) < 40);
        bus.wr_addr    = AW'($urandom_range(hi));
        bus.wr_data    = $urandom();
        bus.alloc_en   = ($urandom_range(99) < 30);
        bus.alloc_addr = AW'($urandom_range(hi));
        bus.flush      = ($urandom_range(99) < 4);
        for (int p = 0; p < NRD; p++)
            set_rd(p, $urandom_range(99) < 85, int'($urandom_range(hi)));
    endtask

    // Architectural effect of one rising edge with the current inputs.
    task automatic model_edge();
        int wa;
        int aa;
        wa = int'(bus.wr_addr);
        aa = int'(bus.alloc_addr);
        if (!m_ready) begin
            m_sweep++;
            if (m_sweep == NREGS - 1) m_ready = 1'b1;
        end else begin
            if (bus.flush) begin
                foreach (m_pend[k]) m_pend[k] = 1'b0;
            end else begin
                if (bus.wr_en)    m_pend[wa] = 1'b0;
                if (bus.alloc_en) m_pend[aa] = 1'b1;
            end
            m_pend[0] = 1'b0;
            if (bus.wr_en && wa != 0) m_reg[wa] = bus.wr_data;
        end
    endtask

    task automatic check_ports();
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("rd_data[%0d]", p), bus.rd_data[p*XLEN +: XLEN], e_data[p]);
            check($sformatf("rd_busy[%0d]", p), bus.rd_busy[p], e_busy[p]);
        end
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic step();
        int a;
        check("init_done", bus.init_done, m_ready);
        for (int p = 0; p < NRD; p++) begin
            a = int'(bus.rd_addr[p*AW +: AW]);
            e_data[p] = '0;
            e_busy[p] = 1'b0;
            if (m_ready && bus.rd_en[p] && a != 0) begin
                if (bus.wr_en && int'(bus.wr_addr) == a) begin
                    e_data[p] = bus.wr_data;
                end else begin
                    e_data[p] = m_reg[a];
                    e_busy[p] = m_pend[a];
                end
            end
        end
`ifndef REGFILE_SYNC_READ_EN
        @(negedge clk);
        check_ports();
        @(posedge clk);
        model_edge();
        #1;
`else
        @(posedge clk);
        model_edge();
        #1;
        check_ports();
`endif
    endtask

    // Assert reset just after an edge, release it one time unit later.
    task automatic apply_reset();
        rst = 1'b0;
        m_ready = 1'b0;
        m_sweep = 0;
        foreach (m_reg[k])  m_reg[k]  = '0;
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        #1;
        check("rst init_done", bus.init_done, 1'b0);
        check("rst rd_busy", bus.rd_busy, '0);
        rst = 1'b1;
    endtask

    task automatic run_sweep(input string tag);
        int cyc;
        cyc = 0;
        while (bus.init_done !== 1'b1 && cyc < 100) begin
            rand_stim(NREGS - 1);
            step();
            cyc++;
        end
        check(tag, cyc, NREGS - 1);
        idle();
    endtask

    task automatic read_all_regs();
        for (int base = 0; base < NREGS; base += NRD) begin
            idle();
            for (int p = 0; p < NRD; p++) set_rd(p, 1'b1, base + p);
            step();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(posedge clk);
        #1;

        // Fill the array with garbage, then reset: the sweep must zero it.
        apply_reset();
        run_sweep("sweep_len_first");
        for (int r = 1; r < NREGS; r++) begin
            idle();
            set_wr(1'b1, r, $urandom());
            step();
        end
        idle();
        apply_reset();
        run_sweep("sweep_len_garbage");
        read_all_regs();

        // Abort the sweep after 10 cycles; random writes during it must not stick.
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            rand_stim(NREGS - 1);
            step();
        end
        apply_reset();
        run_sweep("sweep_len_restart");
        read_all_regs();

        // Same-cycle write bypass on port 0, then plain read.
        set_wr(1'b1, 5, 32'hDEAD_BEEF);
        set_rd(0, 1'b1, 5);
        step();
        idle();
        set_rd(0, 1'b1, 5);
        step();

        // x0 stays zero.
        set_wr(1'b1, 0, 32'h0000_1234);
        set_rd(0, 1'b1, 0);
        step();
        idle();
        set_rd(0, 1'b1, 0);
        step();

        // All four ports on one register; then one port disabled.
        idle();
        set_wr(1'b1, 7, 32'hA5A5_A5A5);
        step();
        idle();
        for (int p = 0; p < NRD; p++) set_rd(p, 1'b1, 7);
        step();
        set_rd(2, 1'b0, 7);
        step();

        // Scoreboard: alloc, busy read, resolving writeback, alloc+wr collision.
        idle();
        set_alloc(1'b1, 3);
        step();
        idle();
        set_rd(0, 1'b1, 3);
        step();
        set_wr(1'b1, 3, 32'h1357_9BDF);
        step();
        idle();
        set_alloc(1'b1, 3);
        set_wr(1'b1, 3, 32'h2468_ACE0);
        step();
        idle();
        set_rd(0, 1'b1, 3);
        step();

        // Flush wins over a simultaneous alloc.
        idle();
        set_alloc(1'b1, 1); step();
        set_alloc(1'b1, 2); step();
        set_alloc(1'b1, 9); step();
        set_alloc(1'b1, 4);
        bus.flush = 1'b1;
        step();
        idle();
        set_rd(0, 1'b1, 1);
        set_rd(1, 1'b1, 2);
        set_rd(2, 1'b1, 9);
        set_rd(3, 1'b1, 4);
        step();
        set_rd(0, 1'b1, 3);
        step();

        // Random traffic on a narrow address window to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            rand_stim(7);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file, successor to the 2-read/1-write RV32I register file. Sits between the decode and writeback stages.
- Adds configurable XLEN, register count and read-port count.
- Adds a hardware zero-fill sweep after reset and a per-register pending scoreboard for hazard detection.
- Provides write-to-read bypass on every port; x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, ≥4).
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREGS), register address width (derived; never overridden).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-low reset.
- init_done  out  1  high once the zero-fill sweep has finished.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback register index.
- wr_data  in  XLEN  writeback data.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*AW  flattened read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  flattened read data.
- rd_busy  out  NRD  per port: source register still pending.
- alloc_en  in  1  mark a destination register pending (issue).
- alloc_addr  in  AW  destination to mark.
- flush  in  1  clear all pending bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM enters CLEAR; sweep index = 1.
  - pending = 0; init_done = 0; sync-read output registers (if present) = 0.
  - Storage array is not reset directly.
- FSM states and transitions:
  - CLEAR: each cycle writes 0 to reg[index] and increments index. When index = NREGS-1 is written, go to READY next cycle. The sweep takes NREGS-1 cycles after rst deasserts.
  - READY: terminal state; only a reset leaves it.
  - Reset asserted mid-sweep restarts the sweep at index 1.
- During CLEAR:
  - wr_en, alloc_en and flush are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Write (READY only):
  - wr_en && wr_addr != 0 stores wr_data at the rising edge.
  - Writes to x0 are discarded.
- Read port i (READY, combinational path):
  - rd_en[i]=0 or addr=0: data 0.
  - Otherwise, if wr_en && addr == wr_addr: data = wr_data (bypass).
  - Otherwise: data = reg[addr].
  - All ports are independent; any number may read the same register.
- Scoreboard (READY only):
  - pending[wr_addr] clears on a write with wr_en.
  - pending[alloc_addr] sets on alloc_en.
  - alloc and wr to the same address in one cycle: pending ends set (alloc wins).
  - flush clears all bits; flush together with alloc_en: flush wins, pending all 0.
  - pending[0] is always 0.
- rd_busy[i]:
  - = rd_en[i] && addr != 0 && pending[addr] && !(wr_en && wr_addr == addr).
  - The same-cycle writeback resolves the hazard.
- Widths:
  - No arithmetic on data.
  - Sweep index is AW bits wide; it never wraps because the FSM exits at NREGS-1.

Optional Feature:
- Macro REGFILE_SYNC_READ_EN.
- Defined:
  - rd_data and rd_busy are registered, with 1-cycle latency.
  - Address and enables are sampled at edge N; output is valid after edge N.
  - Bypass compares against the wr_* values sampled at that same edge, so the registered data equals the post-write value.
  - Outputs are 0 while init_done=0.
- Undefined:
  - Purely combinational read path as described above, with 0-cycle latency.

Decomposition:
- Package regfile_pkg holds:
  - the default XLEN/NREGS constants;
  - the FSM state encoding (ST_CLEAR=1'b0, ST_READY=1'b1);
  - a zero-register constant.
- One natural sub-module: regfile_rdport. It implements a single read port (select, bypass, busy logic, optional output register) and is instantiated NRD times in a generate loop.

Test Plan:
- Reset sweep:
  - Preload garbage via backdoor; release rst.
  - init_done rises exactly 31 cycles later (NREGS=32).
  - All reads return 0 afterwards.
- Reset mid-sweep:
  - Assert rst at sweep cycle 10, release.
  - init_done takes a full 31 cycles again.
  - wr_en pulses during the sweep have no effect.
- Write/read and bypass:
  - Write x5=0xDEADBEEF while port0 reads x5 in the same cycle: port0 shows 0xDEADBEEF that cycle (comb) or after the edge (SYNC).
  - Write x0=0x1234: reading x0 returns 0.
- Multi-port:
  - NRD=4, all ports read x7=0xA5A5A5A5 simultaneously: all four return the value.
  - A disabled port returns 0.
- Scoreboard:
  - alloc x3; next cycle read x3: rd_busy=1.
  - Write x3 in that cycle: rd_busy=0 and data bypassed.
  - alloc+wr to x3 in the same cycle: pending stays 1.
- Flush:
  - Alloc x1, x2, x9, then flush+alloc x4 in one cycle.
  - All pending bits are 0, including x4.
